// File: rtl/fu_iss_buf.sv
// fu_iss_buf: issue buffer between reservation-station select and the execute stage.
//
// Takes at most one ready instruction per cycle from the RS into an age-ordered circular
// buffer. Each cycle it issues the oldest valid entry through a registered one-cycle pulse
// (fu_iss_vld_o). Issue is held while stall_i is high. On branch resolution, matching entries
// are squashed (recovery) or have their mask bit cleared (prediction correct).
//
// Ports:
//   clk, rst                   clock, asynchronous active-low reset
//   rs_*_i                     incoming instruction from the RS (valid, IR, FU select, dest tag,
//                              ROB index with wrap bit, branch mask, next PC)
//   buf_rdy_o                  buffer can accept an instruction this cycle
//   stall_i                    execute-stage writeback stall, sampled at the edge
//   rob_br_recovery_i          mispredict recovery: squash entries that depend on tag_fix
//   rob_br_pred_correct_i      branch resolved correct: clear tag_fix from all masks
//   rob_br_tag_fix_i           one-hot tag of the resolving branch
//   fu_iss_vld_o, fu_*_o       registered issue pulse and issued instruction fields
//   count_o                    occupied slots, holes included
//
// Optional feature: FU_ISS_BUF_BYPASS_EN. When defined, an instruction that arrives at an
// empty buffer (no valid entries) with no stall goes straight into the output register.

`ifndef FU_SEL_W
`define FU_SEL_W 3
`endif
`ifndef PRF_IDX_W
`define PRF_IDX_W 6
`endif
`ifndef ROB_IDX_W
`define ROB_IDX_W 5
`endif
`ifndef BR_MASK_W
`define BR_MASK_W 4
`endif

module fu_iss_buf #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rs_vld_i,
  input  logic [31:0]            rs_IR_i,
  input  logic [`FU_SEL_W-1:0]   rs_sel_i,
  input  logic [`PRF_IDX_W-1:0]  rs_dest_tag_i,
  input  logic [`ROB_IDX_W:0]    rs_rob_idx_i,
  input  logic [`BR_MASK_W-1:0]  rs_br_mask_i,
  input  logic [63:0]            rs_npc_i,
  output logic                   buf_rdy_o,
  input  logic                   stall_i,
  input  logic                   rob_br_recovery_i,
  input  logic                   rob_br_pred_correct_i,
  input  logic [`BR_MASK_W-1:0]  rob_br_tag_fix_i,
  output logic                   fu_iss_vld_o,
  output logic [`FU_SEL_W-1:0]   fu_sel_o,
  output logic [31:0]            fu_IR_o,
  output logic [`PRF_IDX_W-1:0]  fu_dest_tag_o,
  output logic [`ROB_IDX_W:0]    fu_rob_idx_o,
  output logic [`BR_MASK_W-1:0]  fu_br_mask_o,
  output logic [63:0]            fu_npc_o,
  output logic [IDX_W:0]         count_o
);

  // Entry storage
  logic [31:0]           ir_q   [DEPTH];
  logic [`FU_SEL_W-1:0]  sel_q  [DEPTH];
  logic [`PRF_IDX_W-1:0] tag_q  [DEPTH];
  logic [`ROB_IDX_W:0]   rob_q  [DEPTH];
  logic [63:0]           npc_q  [DEPTH];
  logic [`BR_MASK_W-1:0] mask_q [DEPTH];
  logic [`BR_MASK_W-1:0] mask_d [DEPTH];
  logic [DEPTH-1:0]      vld_q, vld_d;

  logic [IDX_W:0]        head_q, head_d, tail_q, tail_d;
  logic [IDX_W:0]        count;
  logic [IDX_W-1:0]      head_idx, tail_idx, sel_idx, scan_idx;
  logic                  found, sel_kill, in_kill, enq_acc, do_issue, do_bypass, do_write;
  logic                  head_pop;
  logic [`BR_MASK_W-1:0] clr_mask, in_mask;

  // Output register
  logic                  out_vld_q, out_vld_d;
  logic [`FU_SEL_W-1:0]  out_sel_q, out_sel_d;
  logic [31:0]           out_ir_q, out_ir_d;
  logic [`PRF_IDX_W-1:0] out_tag_q, out_tag_d;
  logic [`ROB_IDX_W:0]   out_rob_q, out_rob_d;
  logic [`BR_MASK_W-1:0] out_mask_q, out_mask_d;
  logic [63:0]           out_npc_q, out_npc_d;

  assign count     = tail_q - head_q;
  assign count_o   = count;
  assign buf_rdy_o = (count != (IDX_W + 1)'(DEPTH));
  assign head_idx  = head_q[IDX_W-1:0];
  assign tail_idx  = tail_q[IDX_W-1:0];

  assign clr_mask = rob_br_pred_correct_i ? rob_br_tag_fix_i : '0;
  assign in_mask  = rs_br_mask_i & ~clr_mask;
  assign in_kill  = rob_br_recovery_i & (|(rs_br_mask_i & rob_br_tag_fix_i));
  assign enq_acc  = rs_vld_i & buf_rdy_o;

  // Oldest-first scan from head over the occupied range.
  always_comb begin
    found    = 1'b0;
    sel_idx  = '0;
    scan_idx = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      scan_idx = head_idx + IDX_W'(i);
      if (!found && ((IDX_W + 1)'(i) < count) && vld_q[scan_idx]) begin
        found   = 1'b1;
        sel_idx = scan_idx;
      end
    end
  end

  assign sel_kill = rob_br_recovery_i & (|(mask_q[sel_idx] & rob_br_tag_fix_i));
  assign do_issue = found & ~stall_i & ~sel_kill;

`ifdef FU_ISS_BUF_BYPASS_EN
  assign do_bypass = enq_acc & ~(|vld_q) & ~stall_i & ~in_kill;
`else
  assign do_bypass = 1'b0;
`endif
  assign do_write = enq_acc & ~do_bypass;

  // Head only retires slots already vacated in the current state, one per cycle.
  assign head_pop = (head_q != tail_q) & ~vld_q[head_idx];

  always_comb begin
    head_d = head_pop ? head_q + 1'b1 : head_q;
    tail_d = do_write ? tail_q + 1'b1 : tail_q;
  end

  always_comb begin
    vld_d = vld_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      mask_d[i] = mask_q[i] & ~clr_mask;
      if (rob_br_recovery_i && (|(mask_q[i] & rob_br_tag_fix_i))) begin
        vld_d[i] = 1'b0;
      end
    end
    if (do_issue) begin
      vld_d[sel_idx] = 1'b0;
    end
    if (do_write) begin
      vld_d[tail_idx]  = ~in_kill;
      mask_d[tail_idx] = in_mask;
    end
  end

  // Every edge reloads vld, so a pulse never lasts more than one cycle.
  always_comb begin
    out_vld_d  = 1'b0;
    out_sel_d  = out_sel_q;
    out_ir_d   = out_ir_q;
    out_tag_d  = out_tag_q;
    out_rob_d  = out_rob_q;
    out_npc_d  = out_npc_q;
    out_mask_d = out_mask_q & ~clr_mask;
    if (do_issue) begin
      out_vld_d  = 1'b1;
      out_sel_d  = sel_q[sel_idx];
      out_ir_d   = ir_q[sel_idx];
      out_tag_d  = tag_q[sel_idx];
      out_rob_d  = rob_q[sel_idx];
      out_npc_d  = npc_q[sel_idx];
      out_mask_d = mask_q[sel_idx] & ~clr_mask;
    end else if (do_bypass) begin
      out_vld_d  = 1'b1;
      out_sel_d  = rs_sel_i;
      out_ir_d   = rs_IR_i;
      out_tag_d  = rs_dest_tag_i;
      out_rob_d  = rs_rob_idx_i;
      out_npc_d  = rs_npc_i;
      out_mask_d = in_mask;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      vld_q      <= '0;
      out_vld_q  <= 1'b0;
      out_sel_q  <= '0;
      out_ir_q   <= '0;
      out_tag_q  <= '0;
      out_rob_q  <= '0;
      out_mask_q <= '0;
      out_npc_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mask_q[i] <= '0;
      end
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      vld_q      <= vld_d;
      out_vld_q  <= out_vld_d;
      out_sel_q  <= out_sel_d;
      out_ir_q   <= out_ir_d;
      out_tag_q  <= out_tag_d;
      out_rob_q  <= out_rob_d;
      out_mask_q <= out_mask_d;
      out_npc_q  <= out_npc_d;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mask_q[i] <= mask_d[i];
      end
    end
  end

  // Payload is qualified by vld_q, so it needs no reset.
  always_ff @(posedge clk) begin
    if (do_write) begin
      ir_q[tail_idx]  <= rs_IR_i;
      sel_q[tail_idx] <= rs_sel_i;
      tag_q[tail_idx] <= rs_dest_tag_i;
      rob_q[tail_idx] <= rs_rob_idx_i;
      npc_q[tail_idx] <= rs_npc_i;
    end
  end

  assign fu_iss_vld_o  = out_vld_q;
  assign fu_sel_o      = out_sel_q;
  assign fu_IR_o       = out_ir_q;
  assign fu_dest_tag_o = out_tag_q;
  assign fu_rob_idx_o  = out_rob_q;
  assign fu_br_mask_o  = out_mask_q;
  assign fu_npc_o      = out_npc_q;

endmodule

// File: tb/tb_fu_iss_buf.sv
// Self-checking bench for fu_iss_buf: directed stimulus with a scoreboard of expected issues.

`ifndef FU_SEL_W
`define FU_SEL_W 3
`endif
`ifndef PRF_IDX_W
`define PRF_IDX_W 6
`endif
`ifndef ROB_IDX_W
`define ROB_IDX_W 5
`endif
`ifndef BR_MASK_W
`define BR_MASK_W 4
`endif

module tb_fu_iss_buf;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned IDX_W = 2;
`ifdef FU_ISS_BUF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic                   rs_vld_i = 1'b0;
  logic [31:0]            rs_IR_i = '0;
  logic [`FU_SEL_W-1:0]   rs_sel_i = '0;
  logic [`PRF_IDX_W-1:0]  rs_dest_tag_i = '0;
  logic [`ROB_IDX_W:0]    rs_rob_idx_i = '0;
  logic [`BR_MASK_W-1:0]  rs_br_mask_i = '0;
  logic [63:0]            rs_npc_i = '0;
  logic                   buf_rdy_o;
  logic                   stall_i = 1'b0;
  logic                   rob_br_recovery_i = 1'b0;
  logic                   rob_br_pred_correct_i = 1'b0;
  logic [`BR_MASK_W-1:0]  rob_br_tag_fix_i = '0;
  logic                   fu_iss_vld_o;
  logic [`FU_SEL_W-1:0]   fu_sel_o;
  logic [31:0]            fu_IR_o;
  logic [`PRF_IDX_W-1:0]  fu_dest_tag_o;
  logic [`ROB_IDX_W:0]    fu_rob_idx_o;
  logic [`BR_MASK_W-1:0]  fu_br_mask_o;
  logic [63:0]            fu_npc_o;
  logic [IDX_W:0]         count_o;

  fu_iss_buf #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .rs_vld_i              (rs_vld_i),
    .rs_IR_i               (rs_IR_i),
    .rs_sel_i              (rs_sel_i),
    .rs_dest_tag_i         (rs_dest_tag_i),
    .rs_rob_idx_i          (rs_rob_idx_i),
    .rs_br_mask_i          (rs_br_mask_i),
    .rs_npc_i              (rs_npc_i),
    .buf_rdy_o             (buf_rdy_o),
    .stall_i               (stall_i),
    .rob_br_recovery_i     (rob_br_recovery_i),
    .rob_br_pred_correct_i (rob_br_pred_correct_i),
    .rob_br_tag_fix_i      (rob_br_tag_fix_i),
    .fu_iss_vld_o          (fu_iss_vld_o),
    .fu_sel_o              (fu_sel_o),
    .fu_IR_o               (fu_IR_o),
    .fu_dest_tag_o         (fu_dest_tag_o),
    .fu_rob_idx_o          (fu_rob_idx_o),
    .fu_br_mask_o          (fu_br_mask_o),
    .fu_npc_o              (fu_npc_o),
    .count_o               (count_o)
  );

  typedef struct packed {
    logic [`ROB_IDX_W:0]   rob;
    logic [`BR_MASK_W-1:0] mask;
    logic [31:0]           ir;
    logic [63:0]           npc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Scoreboard: every issue pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst && fu_iss_vld_o) begin
      check_eq("issue_expected", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        check_eq("sb_rob_idx", 64'(fu_rob_idx_o), 64'(e.rob));
        check_eq("sb_br_mask", 64'(fu_br_mask_o), 64'(e.mask));
        check_eq("sb_ir", 64'(fu_IR_o), 64'(e.ir));
        check_eq("sb_npc", fu_npc_o, e.npc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one RS cycle; push selects whether an issue is expected, with the issued mask.
  task automatic enq(input logic [`ROB_IDX_W:0] rob, input logic [`BR_MASK_W-1:0] mask,
                     input bit push, input logic [`BR_MASK_W-1:0] exp_mask);
    exp_t e;
    rs_vld_i      = 1'b1;
    rs_rob_idx_i  = rob;
    rs_br_mask_i  = mask;
    rs_IR_i       = 32'hA000_0000 | 32'(rob);
    rs_npc_i      = 64'h1000 + 64'(rob) * 4;
    rs_sel_i      = 3'd1;
    rs_dest_tag_i = 6'(rob) + 6'd8;
    if (push) begin
      e.rob  = rob;
      e.mask = exp_mask;
      e.ir   = rs_IR_i;
      e.npc  = rs_npc_i;
      sb.push_back(e);
    end
    tick();
    rs_vld_i = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 8 && count_o != 0; i++) tick();
    check_eq(tag, 64'(count_o), 64'd0);
  endtask

  initial begin
    // Reset state
    #12;
    check_eq("rst_count", 64'(count_o), 64'd0);
    check_eq("rst_vld", 64'(fu_iss_vld_o), 64'd0);
    check_eq("rst_rdy", 64'(buf_rdy_o), 64'd1);
    check_eq("rst_rob", 64'(fu_rob_idx_o), 64'd0);
    check_eq("rst_npc", fu_npc_o, 64'd0);
    tick();
    rst = 1'b1;
    tick();

    // Base latency: 2 edges through the buffer, 1 edge with bypass
    enq(6'd5, 4'b0000, 1'b1, 4'b0000);
    check_eq("lat_edge1_vld", 64'(fu_iss_vld_o), 64'(BYP));
    if (BYP) check_eq("lat_byp_rob", 64'(fu_rob_idx_o), 64'd5);
    tick();
    check_eq("lat_edge2_vld", 64'(fu_iss_vld_o), 64'(!BYP));
    if (!BYP) check_eq("lat_buf_rob", 64'(fu_rob_idx_o), 64'd5);
    tick();
    check_eq("lat_pulse_once", 64'(fu_iss_vld_o), 64'd0);
    drain("lat_drain");

    // Fill under stall, drop overflow, then in-order issue
    stall_i = 1'b1;
    for (int k = 1; k <= 4; k++) enq(6'(k), 4'b0000, 1'b1, 4'b0000);
    check_eq("full_rdy", 64'(buf_rdy_o), 64'd0);
    check_eq("full_count", 64'(count_o), 64'd4);
    enq(6'd9, 4'b0000, 1'b0, 4'b0000);
    check_eq("full_drop_count", 64'(count_o), 64'd4);
    check_eq("full_stall_vld", 64'(fu_iss_vld_o), 64'd0);
    stall_i = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      check_eq("order_vld", 64'(fu_iss_vld_o), 64'd1);
      check_eq("order_rob", 64'(fu_rob_idx_o), 64'(k));
    end
    drain("order_drain");

    // Recovery squashes dependents of tag 0001
    stall_i = 1'b1;
    enq(6'd10, 4'b0001, 1'b0, 4'b0000);
    enq(6'd11, 4'b0010, 1'b1, 4'b0010);
    enq(6'd12, 4'b0001, 1'b0, 4'b0000);
    rob_br_recovery_i = 1'b1;
    rob_br_tag_fix_i  = 4'b0001;
    tick();
    rob_br_recovery_i = 1'b0;
    stall_i = 1'b0;
    tick();
    check_eq("rec_issue_vld", 64'(fu_iss_vld_o), 64'd1);
    check_eq("rec_issue_rob", 64'(fu_rob_idx_o), 64'd11);
    tick();
    tick();
    check_eq("rec_drain3", 64'(count_o), 64'd0);
    drain("rec_drain");

    // Prediction correct clears the resolving bit in a held entry
    stall_i = 1'b1;
    enq(6'd7, 4'b0110, 1'b1, 4'b0010);
    rob_br_pred_correct_i = 1'b1;
    rob_br_tag_fix_i      = 4'b0100;
    tick();
    rob_br_pred_correct_i = 1'b0;
    stall_i = 1'b0;
    tick();
    check_eq("pc_vld", 64'(fu_iss_vld_o), 64'd1);
    check_eq("pc_mask", 64'(fu_br_mask_o), 64'b0010);
    drain("pc_drain");

    // Two-cycle stall holds two valid entries
    stall_i = 1'b1;
    enq(6'd20, 4'b0000, 1'b1, 4'b0000);
    enq(6'd21, 4'b0000, 1'b1, 4'b0000);
    for (int k = 0; k < 2; k++) begin
      tick();
      check_eq("stall_no_issue", 64'(fu_iss_vld_o), 64'd0);
    end
    stall_i = 1'b0;
    tick();
    check_eq("stall_rel1_vld", 64'(fu_iss_vld_o), 64'd1);
    check_eq("stall_rel1_rob", 64'(fu_rob_idx_o), 64'd20);
    tick();
    check_eq("stall_rel2_vld", 64'(fu_iss_vld_o), 64'd1);
    check_eq("stall_rel2_rob", 64'(fu_rob_idx_o), 64'd21);
    drain("stall_drain");

    // Mid-stream reset with 3 entries held
    stall_i = 1'b1;
    for (int k = 0; k < 3; k++) enq(6'(30 + k), 4'b0000, 1'b0, 4'b0000);
    check_eq("pre_rst_count", 64'(count_o), 64'd3);
    #3;
    rst = 1'b0;
    tick();
    check_eq("mid_rst_count", 64'(count_o), 64'd0);
    check_eq("mid_rst_vld", 64'(fu_iss_vld_o), 64'd0);
    check_eq("mid_rst_rdy", 64'(buf_rdy_o), 64'd1);
    rst = 1'b1;
    stall_i = 1'b0;
    tick();
    tick();

    check_eq("sb_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fu_iss_buf.md
# fu_iss_buf

Issue buffer between the reservation-station select logic and the execute stage. Accepts up to one ready instruction per cycle from the RS and holds it in an age-ordered buffer. Presents the oldest live entry to the functional units through a registered one-cycle issue pulse. Holds issue while the execute stage signals a writeback stall, and squashes or clears branch-mask state on ROB branch resolution.

## Interface
Parameters:
- DEPTH, 4, buffer entries; a power of two, ≥2
- IDX_W, $clog2(DEPTH), pointer width

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset
- rs_vld_i  in  1  RS presents an instruction this cycle
- rs_IR_i  in  32  instruction word
- rs_sel_i  in  `FU_SEL_W  functional-unit select
- rs_dest_tag_i  in  `PRF_IDX_W  destination physical tag
- rs_rob_idx_i  in  `ROB_IDX_W+1  ROB index including the wrap bit
- rs_br_mask_i  in  `BR_MASK_W  branch dependence mask
- rs_npc_i  in  64  next PC
- buf_rdy_o  out  1  buffer can accept an instruction this cycle
- stall_i  in  1  execute-stage writeback stall (load/STC commit-ready conflict)
- rob_br_recovery_i  in  1  mispredict recovery
- rob_br_pred_correct_i  in  1  branch resolved correct
- rob_br_tag_fix_i  in  `BR_MASK_W  one-hot tag of the resolving branch
- fu_iss_vld_o  out  1  issue pulse to the execute stage
- fu_sel_o, fu_IR_o, fu_dest_tag_o, fu_rob_idx_o, fu_br_mask_o, fu_npc_o  out  same widths as the rs_* inputs  issued instruction fields
- count_o  out  IDX_W+1  occupied slots, holes included

## Operation
- Storage: circular buffer with head and tail pointers (IDX_W+1 bits, wrap bit included), plus a per-entry valid bit.
- count = tail − head. Full when count == DEPTH. buf_rdy_o = ~full, combinational from the current state.
- Enqueue: when rs_vld_i & buf_rdy_o, write the entry at tail, set it valid, and increment tail. rs_vld_i while ~buf_rdy_o is ignored and is an RS protocol error.
- Select: the first valid entry scanning from head to tail−1 (oldest first).
- Issue: if a valid entry is selected and stall_i = 0 at an edge, copy it into the output register with vld = 1 and clear its valid bit. Otherwise load the output register with vld = 0.
- Every output-register load is a fresh load, so each instruction pulses fu_iss_vld_o for exactly one cycle.
- Head advance: at most +1 per cycle, when the head entry is invalid (issued or squashed) and head ≠ tail.
- Recovery, when rob_br_recovery_i = 1:
  - Clear valid on every entry with (br_mask & tag_fix) ≠ 0.
  - An enqueuing instruction that matches is written invalid.
  - A matching selected entry is not issued.
  - The output register vld is cleared at the edge if its mask matches.
- Pred correct, when rob_br_pred_correct_i = 1: clear the tag_fix bit in every entry mask, in the incoming mask, and in the output register mask.
- Recovery and pred correct are never asserted together.
- Reset: head = tail = 0, all valid = 0, fu_iss_vld_o = 0, and all fu_* fields = 0. buf_rdy_o = 1 and count_o = 0.

## Timing
- Base latency: enqueue at edge N, issue at edge N+1. fu_iss_vld_o is high for the cycle after edge N+1.
- stall_i is sampled only at the edge, so there is no combinational path from stall_i or from any fu_* output back into the outputs.
- The execute-stage stall derived from the current issue pulse can therefore only delay later issues.
- Simultaneous enqueue into a full buffer plus a head pop is not accepted, because buf_rdy_o is computed before the pop.
- Enqueue and issue of different entries in the same cycle are both performed.
- Pointer wrap: the wrap bit distinguishes full from empty at index equality.

## Configuration
- FU_ISS_BUF_BYPASS_EN defined:
  - Applies when no valid entry exists, stall_i = 0, rs_vld_i = 1, and the incoming instruction is not squashed.
  - The instruction loads the output register directly at edge N; nothing is written to the buffer.
  - Latency is 1 edge.
- Not defined: every instruction passes through the buffer, with latency 2 edges.

## Test plan
- Reset low mid-stream with 3 entries held → next cycle count_o = 0, fu_iss_vld_o = 0, buf_rdy_o = 1.
- Enqueue ALU rob_idx 5 into an empty buffer without bypass → fu_iss_vld_o = 1 with rob_idx 5 exactly one cycle, two edges after enqueue. With FU_ISS_BUF_BYPASS_EN → one edge after enqueue.
- Enqueue 4 instructions back-to-back with DEPTH = 4 and stall_i = 1 → buf_rdy_o = 0 and count_o = 4. A 5th rs_vld_i is dropped. Release the stall → issue order rob_idx 1, 2, 3, 4 on consecutive cycles.
- Entries with masks 0001, 0010, 0001 and recovery with tag_fix 0001 → only the 0010 entry issues. count_o drains to 0 within 3 cycles.
- Entry with mask 0110 and pred_correct with tag_fix 0100 → the issued fu_br_mask_o = 0010.
- stall_i = 1 for exactly 2 cycles with 2 valid entries → no issue pulse during the stall. Issues occur on the two edges after stall_i falls.
